// File: rtl/valu_result_buffer_pkg.sv
// Shared vALU definitions for the result buffer: default widths, depth and
// the occupancy/credit counter width helper.
package valu_result_buffer_pkg;

   localparam int VALU_DATA_WIDTH = 64;
   localparam int VALU_RB_DEPTH   = 8;

   // Counter must represent 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   typedef struct packed {
      logic overflow;
      logic spurious;
   } rb_err_t;

endpackage

// File: rtl/valu_result_buffer_if.sv
// Issue-credit, pipe-result and writeback signals of the vALU result buffer.
interface valu_result_buffer_if
   import valu_result_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = VALU_DATA_WIDTH,
   parameter int DEPTH      = VALU_RB_DEPTH
);
   localparam int CNT_W = cnt_w(DEPTH);

   logic                  issue_valid;
   logic                  issue_ready;
   logic                  res_valid;
   logic [DATA_WIDTH-1:0] res_data;
   logic                  wb_valid;
   logic [DATA_WIDTH-1:0] wb_data;
   logic                  wb_ready;
   logic [CNT_W-1:0]      occupancy;
   logic                  err_overflow;
   logic                  err_spurious;

   modport slave (
      input  issue_valid, res_valid, res_data, wb_ready,
      output issue_ready, wb_valid, wb_data, occupancy, err_overflow, err_spurious
   );

   modport master (
      output issue_valid, res_valid, res_data, wb_ready,
      input  issue_ready, wb_valid, wb_data, occupancy, err_overflow, err_spurious
   );

endinterface

// File: rtl/valu_sync_fifo.sv
// First-word-fall-through synchronous FIFO; the caller only pushes when not
// full (or popping in the same cycle) and only pops when not empty.
module valu_sync_fifo
   import valu_result_buffer_pkg::*;
#(
   parameter  int DATA_WIDTH = VALU_DATA_WIDTH,
   parameter  int DEPTH      = VALU_RB_DEPTH,
   localparam int CNT_W      = cnt_w(DEPTH),
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0]      occupancy,
   output logic                  full,
   output logic                  empty
);

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      occ_q, occ_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   occ_d = occ_q + CNT_W'(1);
         2'b01:   occ_d = occ_q - CNT_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Storage is deliberately left out of reset; occupancy gates its visibility.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end

   assign rd_data   = mem_q[rd_ptr_q];
   assign occupancy = occ_q;
   assign full      = (occ_q == CNT_W'(DEPTH));
   assign empty     = (occ_q == '0);

endmodule

// File: rtl/valu_result_buffer.sv
// Collects results from the non-stallable vALU pipes and hands them to
// writeback; issue is credit-gated so every launched op has a reserved slot.
module valu_result_buffer
   import valu_result_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = VALU_DATA_WIDTH,
   parameter int DEPTH      = VALU_RB_DEPTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   valu_result_buffer_if.slave  bus
);

   localparam int CNT_W = cnt_w(DEPTH);

   logic                  issue_fire;
   logic                  res_retire;
   logic                  push;
   logic                  pop;
   logic                  full;
   logic                  empty;
   logic [CNT_W-1:0]      occ;
   logic [CNT_W:0]        credit_used;
   logic [DATA_WIDTH-1:0] head_data;
   logic [CNT_W-1:0]      inflight_q, inflight_d;
   rb_err_t               err_q, err_d;

   // Credit looks only at registered counters so issue_ready has no path
   // from res_valid or wb_ready.
   assign credit_used     = {1'b0, inflight_q} + {1'b0, occ};
   assign bus.issue_ready = (credit_used < (CNT_W+1)'(DEPTH));

   assign issue_fire = bus.issue_valid & bus.issue_ready;
   assign res_retire = bus.res_valid & (inflight_q != '0);
   assign pop        = ~empty & bus.wb_ready;
   assign push       = bus.res_valid & (~full | pop);

   always_comb begin
      inflight_d = inflight_q;
      err_d      = err_q;
      case ({issue_fire, res_retire})
         2'b10:   inflight_d = inflight_q + CNT_W'(1);
         2'b01:   inflight_d = inflight_q - CNT_W'(1);
         default: inflight_d = inflight_q;
      endcase
      if (bus.res_valid & full & ~pop)     err_d.overflow = 1'b1;
      if (bus.res_valid & (inflight_q == '0)) err_d.spurious = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q <= '0;
         err_q      <= '0;
      end else begin
         inflight_q <= inflight_d;
         err_q      <= err_d;
      end
   end

   valu_sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (bus.res_data),
      .pop       (pop),
      .rd_data   (head_data),
      .occupancy (occ),
      .full      (full),
      .empty     (empty)
   );

   assign bus.wb_valid     = ~empty;
   assign bus.wb_data      = head_data;
   assign bus.occupancy    = occ;
   assign bus.err_overflow = err_q.overflow;
   assign bus.err_spurious = err_q.spurious;

endmodule

// File: tb/tb_valu_result_buffer.sv
// Scenario bench for valu_result_buffer with a queue scoreboard of expected
// writeback words.
module tb_valu_result_buffer;
   import valu_result_buffer_pkg::*;

   localparam int DW    = 64;
   localparam int DEPTH = 8;
   localparam int CNT_W = cnt_w(DEPTH);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   int            total = 0;
   int            bad = 0;
   logic [DW-1:0] sb [$];
   logic [DW-1:0] exp_d;

   valu_result_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

   valu_result_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.issue_valid = 1'b0;
      bus.res_valid   = 1'b0;
      bus.res_data    = '0;
      bus.wb_ready    = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      bus.res_valid = 1'b1; bus.res_data = 64'h1234;
      tick();
      bus.res_valid = 1'b0;
      total++; if (bus.occupancy !== CNT_W'(1)) begin bad++; $display("FAIL pre_rst_occ: got %0d want 1", bus.occupancy); end
      total++; if (bus.err_spurious !== 1'b1) begin bad++; $display("FAIL pre_rst_spurious: got %b want 1", bus.err_spurious); end
      #3 rst_n = 1'b0;
      #1;
      total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid: got %b want 0", bus.wb_valid); end
      total++; if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL rst_issue_ready: got %b want 1", bus.issue_ready); end
      total++; if (bus.occupancy !== CNT_W'(0)) begin bad++; $display("FAIL rst_occ: got %0d want 0", bus.occupancy); end
      total++; if (bus.err_overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b want 0", bus.err_overflow); end
      total++; if (bus.err_spurious !== 1'b0) begin bad++; $display("FAIL rst_spurious: got %b want 0", bus.err_spurious); end
      tick();
      rst_n = 1'b1;
      tick();
      sb.delete();
   endtask

   task automatic test_single();
      idle_inputs();
      bus.wb_ready = 1'b1;
      bus.issue_valid = 1'b1;
      total++; if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL single_issue_ready: got %b want 1", bus.issue_ready); end
      tick();
      bus.issue_valid = 1'b0;
      repeat (5) tick();
      bus.res_valid = 1'b1; bus.res_data = 64'hDEAD_BEEF;
      sb.push_back(64'hDEAD_BEEF);
      tick();
      bus.res_valid = 1'b0;
      total++; if (bus.wb_valid !== 1'b1) begin bad++; $display("FAIL single_wb_valid: got %b want 1", bus.wb_valid); end
      total++; if (bus.occupancy !== CNT_W'(1)) begin bad++; $display("FAIL single_occ1: got %0d want 1", bus.occupancy); end
      exp_d = sb.pop_front();
      total++; if (bus.wb_data !== exp_d) begin bad++; $display("FAIL single_wb_data: got %h want %h", bus.wb_data, exp_d); end
      tick();
      total++; if (bus.occupancy !== CNT_W'(0)) begin bad++; $display("FAIL single_occ0: got %0d want 0", bus.occupancy); end
      total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL single_wb_idle: got %b want 0", bus.wb_valid); end
      total++; if (bus.err_spurious !== 1'b0) begin bad++; $display("FAIL single_spurious: got %b want 0", bus.err_spurious); end
      bus.wb_ready = 1'b0;
   endtask

   task automatic test_credit();
      idle_inputs();
      bus.issue_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         total++; if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL credit_open_%0d: got %b want 1", i, bus.issue_ready); end
         tick();
      end
      total++; if (bus.issue_ready !== 1'b0) begin bad++; $display("FAIL credit_exhausted: got %b want 0", bus.issue_ready); end
      tick();
      bus.issue_valid = 1'b0;
      total++; if (bus.issue_ready !== 1'b0) begin bad++; $display("FAIL credit_ninth: got %b want 0", bus.issue_ready); end
      for (int i = 0; i < 8; i++) begin
         bus.res_valid = 1'b1; bus.res_data = DW'(100 + i);
         sb.push_back(DW'(100 + i));
         tick();
      end
      bus.res_valid = 1'b0;
      total++; if (bus.occupancy !== CNT_W'(8)) begin bad++; $display("FAIL credit_occ8: got %0d want 8", bus.occupancy); end
      repeat (2) tick();
      total++; if (bus.wb_data !== 64'd100) begin bad++; $display("FAIL credit_head_hold: got %h want %h", bus.wb_data, 64'd100); end
      bus.wb_ready = 1'b1;
      exp_d = sb.pop_front();
      total++; if (bus.wb_data !== exp_d) begin bad++; $display("FAIL credit_pop0: got %h want %h", bus.wb_data, exp_d); end
      tick();
      bus.wb_ready = 1'b0;
      total++; if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL credit_reopen: got %b want 1", bus.issue_ready); end
      total++; if (bus.occupancy !== CNT_W'(7)) begin bad++; $display("FAIL credit_occ7: got %0d want 7", bus.occupancy); end
      bus.wb_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         exp_d = sb.pop_front();
         total++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== exp_d) begin bad++; $display("FAIL credit_drain_%0d: got %b/%h want 1/%h", i, bus.wb_valid, bus.wb_data, exp_d); end
         tick();
      end
      bus.wb_ready = 1'b0;
      total++; if (bus.occupancy !== CNT_W'(0)) begin bad++; $display("FAIL credit_empty: got %0d want 0", bus.occupancy); end
      total++; if (bus.err_spurious !== 1'b0 || bus.err_overflow !== 1'b0) begin bad++; $display("FAIL credit_errs: got %b%b want 00", bus.err_overflow, bus.err_spurious); end
   endtask

   task automatic test_wrap();
      int   k = 0;
      int   launched = 0;
      int   returned = 0;
      int   popped = 0;
      int   tq [$];
      logic fire;
      idle_inputs();
      while (popped < 20 && k < 400) begin
         bus.issue_valid = (launched < 20);
         fire = bus.issue_valid & bus.issue_ready;
         if (fire) begin
            tq.push_back(k + 6);
            launched++;
         end
         if (tq.size() != 0 && tq[0] == k) begin
            void'(tq.pop_front());
            bus.res_valid = 1'b1; bus.res_data = DW'(returned);
            sb.push_back(DW'(returned));
            returned++;
         end else begin
            bus.res_valid = 1'b0;
         end
         bus.wb_ready = k[0];
         if (bus.wb_valid === 1'b1 && bus.wb_ready === 1'b1) begin
            if (sb.size() == 0) begin
               total++; bad++; $display("FAIL wrap_unexpected: got %h want no output", bus.wb_data);
            end else begin
               exp_d = sb.pop_front();
               total++; if (bus.wb_data !== exp_d) begin bad++; $display("FAIL wrap_data_%0d: got %h want %h", popped, bus.wb_data, exp_d); end
            end
            popped++;
         end
         tick();
         k++;
      end
      idle_inputs();
      total++; if (popped != 20) begin bad++; $display("FAIL wrap_timeout: got %0d pops want 20", popped); end
      total++; if (bus.occupancy !== CNT_W'(0)) begin bad++; $display("FAIL wrap_empty: got %0d want 0", bus.occupancy); end
      total++; if (bus.err_spurious !== 1'b0 || bus.err_overflow !== 1'b0) begin bad++; $display("FAIL wrap_errs: got %b%b want 00", bus.err_overflow, bus.err_spurious); end
   endtask

   task automatic test_full_pushpop();
      idle_inputs();
      bus.issue_valid = 1'b1;
      repeat (8) tick();
      bus.issue_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.res_valid = 1'b1; bus.res_data = DW'(200 + i);
         sb.push_back(DW'(200 + i));
         tick();
      end
      bus.res_valid = 1'b0;
      total++; if (bus.occupancy !== CNT_W'(8)) begin bad++; $display("FAIL full_occ8: got %0d want 8", bus.occupancy); end
      bus.res_valid = 1'b1; bus.res_data = 64'd300; bus.wb_ready = 1'b1;
      exp_d = sb.pop_front();
      total++; if (bus.wb_data !== exp_d) begin bad++; $display("FAIL full_pop_head: got %h want %h", bus.wb_data, exp_d); end
      sb.push_back(64'd300);
      tick();
      bus.res_valid = 1'b0; bus.wb_ready = 1'b0;
      total++; if (bus.occupancy !== CNT_W'(8)) begin bad++; $display("FAIL full_occ_hold: got %0d want 8", bus.occupancy); end
      total++; if (bus.wb_data !== sb[0]) begin bad++; $display("FAIL full_head_adv: got %h want %h", bus.wb_data, sb[0]); end
      total++; if (bus.err_overflow !== 1'b0) begin bad++; $display("FAIL full_no_overflow: got %b want 0", bus.err_overflow); end
      total++; if (bus.err_spurious !== 1'b1) begin bad++; $display("FAIL full_spurious: got %b want 1", bus.err_spurious); end
      bus.wb_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp_d = sb.pop_front();
         total++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== exp_d) begin bad++; $display("FAIL full_drain_%0d: got %b/%h want 1/%h", i, bus.wb_valid, bus.wb_data, exp_d); end
         tick();
      end
      bus.wb_ready = 1'b0;
      total++; if (bus.occupancy !== CNT_W'(0)) begin bad++; $display("FAIL full_empty: got %0d want 0", bus.occupancy); end
   endtask

   task automatic test_errors();
      idle_inputs();
      #3 rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      sb.delete();
      total++; if (bus.err_spurious !== 1'b0) begin bad++; $display("FAIL err_clear_start: got %b want 0", bus.err_spurious); end
      bus.res_valid = 1'b1; bus.res_data = 64'd500;
      sb.push_back(64'd500);
      tick();
      bus.res_valid = 1'b0;
      total++; if (bus.err_spurious !== 1'b1) begin bad++; $display("FAIL err_spurious_set: got %b want 1", bus.err_spurious); end
      total++; if (bus.occupancy !== CNT_W'(1) || bus.wb_data !== 64'd500) begin bad++; $display("FAIL err_spurious_pushed: got %0d/%h want 1/%h", bus.occupancy, bus.wb_data, 64'd500); end
      total++; if (bus.err_overflow !== 1'b0) begin bad++; $display("FAIL err_overflow_early: got %b want 0", bus.err_overflow); end
      for (int i = 0; i < 7; i++) begin
         bus.res_valid = 1'b1; bus.res_data = DW'(501 + i);
         sb.push_back(DW'(501 + i));
         tick();
      end
      total++; if (bus.occupancy !== CNT_W'(8)) begin bad++; $display("FAIL err_fill: got %0d want 8", bus.occupancy); end
      bus.res_valid = 1'b1; bus.res_data = 64'hBAD;
      tick();
      bus.res_valid = 1'b0;
      total++; if (bus.err_overflow !== 1'b1) begin bad++; $display("FAIL err_overflow_set: got %b want 1", bus.err_overflow); end
      total++; if (bus.occupancy !== CNT_W'(8)) begin bad++; $display("FAIL err_overflow_occ: got %0d want 8", bus.occupancy); end
      bus.wb_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp_d = sb.pop_front();
         total++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== exp_d) begin bad++; $display("FAIL err_drain_%0d: got %b/%h want 1/%h", i, bus.wb_valid, bus.wb_data, exp_d); end
         tick();
      end
      bus.wb_ready = 1'b0;
      repeat (3) tick();
      total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL err_dropped_gone: got %b want 0", bus.wb_valid); end
      total++; if (bus.err_overflow !== 1'b1 || bus.err_spurious !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b%b want 11", bus.err_overflow, bus.err_spurious); end
      #3 rst_n = 1'b0;
      #1;
      total++; if (bus.err_overflow !== 1'b0 || bus.err_spurious !== 1'b0) begin bad++; $display("FAIL err_rst_clear: got %b%b want 00", bus.err_overflow, bus.err_spurious); end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single();
      test_credit();
      test_wrap();
      test_full_pushpop();
      test_errors();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
